// File: rtl/apb_pwm_regbank.sv
// APB register bank for the multi-channel PWM block. It holds PERIOD, PULSE, SIZE and ENABLE
// for each channel. PERIOD and PULSE are double-buffered, so a generator only sees a new value
// at its own period boundary.
module apb_pwm_regbank #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [11:0]          PADDR,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [N_CH-1:0]      reload_i,
  output logic [N_CH*DW-1:0]   period_o,
  output logic [N_CH*DW-1:0]   pulse_o,
  output logic [N_CH*8-1:0]    size_o,
  output logic [N_CH-1:0]      enable_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  localparam logic [2:0] WsLast = 3'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              xfer_done, addr_err, wr_en;
  logic [N_CH-1:0]   ch_hit;
  logic [31:0]       rdata_mux;

  logic [DW-1:0]     sh_per_q  [N_CH];
  logic [DW-1:0]     sh_per_d  [N_CH];
  logic [DW-1:0]     sh_pul_q  [N_CH];
  logic [DW-1:0]     sh_pul_d  [N_CH];
  logic [DW-1:0]     act_per_q [N_CH];
  logic [DW-1:0]     act_per_d [N_CH];
  logic [DW-1:0]     act_pul_q [N_CH];
  logic [DW-1:0]     act_pul_d [N_CH];
  logic [7:0]        size_q    [N_CH];
  logic [7:0]        size_d    [N_CH];
  logic [N_CH-1:0]   enable_q, enable_d;
  logic [N_CH-1:0]   pend_q, pend_d;

  // State register for the APB transfer FSM and its wait counter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. StSetup is the first enable cycle and StAccess covers the remaining wait
  // cycles. Dropping PSEL before completion abandons the transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (PSEL && !PENABLE) state_d = StSetup;
      end
      StSetup, StAccess: begin
        if (!PSEL || xfer_done) begin
          state_d = StIdle;
        end else if (PENABLE) begin
          cnt_d   = cnt_q + 3'd1;
          state_d = StAccess;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Address decode. Channel index comparison only applies below the STATUS address.
  always_comb begin
    addr_err = 1'b0;
    if (PADDR[1:0] != 2'b00) begin
      addr_err = 1'b1;
    end else if (PADDR >= 12'h104) begin
      addr_err = 1'b1;
    end else if (PADDR[11:8] == 4'h1) begin
      addr_err = PWRITE;
    end else if (32'(PADDR[7:4]) >= N_CH) begin
      addr_err = 1'b1;
    end
    for (int c = 0; c < N_CH; c++) begin
      ch_hit[c] = (PADDR[11:8] == 4'h0) && (PADDR[7:4] == 4'(c));
    end
  end

  // Read mux. PERIOD and PULSE return the shadow copy, not the active one.
  always_comb begin
    rdata_mux = '0;
    if (PADDR[11:8] == 4'h1) begin
      for (int c = 0; c < N_CH; c++) rdata_mux[c] = pend_q[c];
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_hit[c]) begin
          unique case (PADDR[3:2])
            2'd0: rdata_mux = 32'(sh_per_q[c]);
            2'd1: rdata_mux = 32'(sh_pul_q[c]);
            2'd2: rdata_mux = 32'(size_q[c]);
            2'd3: rdata_mux = 32'(enable_q[c]);
          endcase
        end
      end
    end
  end

  // Bus outputs. Completion is suppressed during reset, so nothing commits in that cycle.
  always_comb begin
    xfer_done = (state_q != StIdle) && PSEL && PENABLE && (cnt_q == WsLast) && !PRESET;
    PREADY    = xfer_done;
    PSLVERR   = xfer_done && addr_err;
    PRDATA    = (xfer_done && !addr_err && !PWRITE) ? rdata_mux : '0;
    wr_en     = xfer_done && PWRITE && !addr_err;
  end

  // Register next state. The reload copy uses the old shadow value before any write is applied,
  // so a write in a reload cycle stays pending.
  always_comb begin
    sh_per_d  = sh_per_q;
    sh_pul_d  = sh_pul_q;
    act_per_d = act_per_q;
    act_pul_d = act_pul_q;
    size_d    = size_q;
    enable_d  = enable_q;
    pend_d    = pend_q;
    for (int c = 0; c < N_CH; c++) begin
      if (reload_i[c] || !enable_q[c]) begin
        act_per_d[c] = sh_per_q[c];
        act_pul_d[c] = sh_pul_q[c];
        pend_d[c]    = 1'b0;
      end
      if (wr_en && ch_hit[c]) begin
        unique case (PADDR[3:2])
          2'd0: begin sh_per_d[c] = PWDATA[DW-1:0]; pend_d[c] = 1'b1; end
          2'd1: begin sh_pul_d[c] = PWDATA[DW-1:0]; pend_d[c] = 1'b1; end
          2'd2: size_d[c]   = PWDATA[7:0];
          2'd3: enable_d[c] = PWDATA[0];
        endcase
      end
    end
  end

  // Channel register storage.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sh_per_q  <= '{default: '0};
      sh_pul_q  <= '{default: '0};
      act_per_q <= '{default: '0};
      act_pul_q <= '{default: '0};
      size_q    <= '{default: '0};
      enable_q  <= '0;
      pend_q    <= '0;
    end else begin
      sh_per_q  <= sh_per_d;
      sh_pul_q  <= sh_pul_d;
      act_per_q <= act_per_d;
      act_pul_q <= act_pul_d;
      size_q    <= size_d;
      enable_q  <= enable_d;
      pend_q    <= pend_d;
    end
  end

  // Pack the per-channel values onto the generator-facing buses.
  always_comb begin
    period_o = '0;
    pulse_o  = '0;
    size_o   = '0;
    for (int c = 0; c < N_CH; c++) begin
      period_o[c*DW +: DW] = act_per_q[c];
      pulse_o[c*DW +: DW]  = act_pul_q[c];
      size_o[c*8 +: 8]     = size_q[c];
    end
    enable_o = enable_q;
  end

endmodule

// File: tb/tb_apb_pwm_regbank.sv
// Testbench for apb_pwm_regbank. It drives one zero-wait-state instance and one instance with
// three wait states, and compares them against a per-channel array model.
`timescale 1ns/1ps
module tb_apb_pwm_regbank;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam logic [31:0] DMASK = 32'((64'h1 << DW) - 1);

  logic pclk = 1'b0, preset = 1'b1, psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [NCH-1:0] reload = '0;

  logic [31:0] prdata0, prdata3;
  logic pready0, pready3, pslverr0, pslverr3;
  logic [NCH*DW-1:0] period0, period3, pulse0, pulse3;
  logic [NCH*8-1:0] size0, size3;
  logic [NCH-1:0] enable0, enable3;

  int checks = 0, errors = 0;

  // Model of the zero-wait instance.
  logic [31:0] m_sh_per [NCH], m_sh_pul [NCH], m_act_per [NCH], m_act_pul [NCH];
  logic [7:0] m_size [NCH];
  bit m_en [NCH], m_pend [NCH];

  always #5 pclk = ~pclk;

  apb_pwm_regbank #(.N_CH(NCH), .DW(DW), .WAIT_STATES(0)) dut0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .reload_i(reload), .period_o(period0), .pulse_o(pulse0), .size_o(size0), .enable_o(enable0)
  );

  apb_pwm_regbank #(.N_CH(NCH), .DW(DW), .WAIT_STATES(3)) dut3 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .reload_i(reload), .period_o(period3), .pulse_o(pulse3), .size_o(size3), .enable_o(enable3)
  );

  function automatic bit exp_err(input bit w, input logic [11:0] a);
    if (a[1:0] != 2'b00) return 1'b1;
    if (a >= 12'h104) return 1'b1;
    if (a == 12'h100) return w;
    return int'(a[7:4]) >= NCH;
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    logic [31:0] r;
    int ch;
    r = '0;
    if (exp_err(1'b0, a)) return '0;
    if (a == 12'h100) begin
      for (int c = 0; c < NCH; c++) r[c] = m_pend[c];
      return r;
    end
    ch = int'(a[7:4]);
    case (a[3:0])
      4'h0: r = m_sh_per[ch];
      4'h4: r = m_sh_pul[ch];
      4'h8: r = {24'h0, m_size[ch]};
      default: r = {31'h0, m_en[ch]};
    endcase
    return r;
  endfunction

  // Step the model across one rising edge, then move to 1ns after that edge.
  task automatic tick(input bit commit, input logic [11:0] a, input logic [31:0] d);
    int ch;
    if (preset) begin
      for (int c = 0; c < NCH; c++) begin
        m_sh_per[c] = 0; m_sh_pul[c] = 0; m_act_per[c] = 0; m_act_pul[c] = 0;
        m_size[c] = 0; m_en[c] = 0; m_pend[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (reload[c] || !m_en[c]) begin
          m_act_per[c] = m_sh_per[c];
          m_act_pul[c] = m_sh_pul[c];
          m_pend[c] = 0;
        end
      end
      if (commit) begin
        ch = int'(a[7:4]);
        case (a[3:0])
          4'h0: begin m_sh_per[ch] = d & DMASK; m_pend[ch] = 1; end
          4'h4: begin m_sh_pul[ch] = d & DMASK; m_pend[ch] = 1; end
          4'h8: m_size[ch] = d[7:0];
          default: m_en[ch] = d[0];
        endcase
      end
    end
    @(posedge pclk);
    #1;
  endtask

  // Zero-wait transfer on dut0. rl is driven only in the access cycle.
  task automatic apb0(input bit w, input logic [11:0] a, input logic [31:0] d,
                      input logic [NCH-1:0] rl, output logic [31:0] rd, output logic er,
                      output logic [31:0] erd, output logic eer);
    psel0 = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    #1;
    checks++;
    if (pready0 !== 1'b0) begin
      errors++; $display("FAIL setup_pready addr=%h got=%b exp=0", a, pready0);
    end
    tick(1'b0, a, d);
    penable = 1; reload = rl;
    #1;
    checks++;
    if (pready0 !== 1'b1) begin
      errors++; $display("FAIL access_pready addr=%h got=%b exp=1", a, pready0);
    end
    rd = prdata0; er = pslverr0;
    erd = w ? 32'h0 : exp_read(a);
    eer = exp_err(w, a);
    tick(w && !exp_err(w, a), a, d);
    psel0 = 0; penable = 0; reload = '0;
    #1;
    checks++;
    if (pready0 !== 1'b0) begin
      errors++; $display("FAIL pready_width addr=%h got=%b exp=0", a, pready0);
    end
  endtask

  // Transfer on dut3. lat is the number of enable cycles before PREADY, or -1 on timeout.
  task automatic apb3(input bit w, input logic [11:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    psel3 = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    tick(1'b0, a, d);
    penable = 1;
    lat = -1; rd = '0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (pready3 === 1'b1) begin
        lat = k; rd = prdata3;
        break;
      end
      tick(1'b0, a, d);
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL apb3_timeout addr=%h got=no_pready exp=pready", a);
    end else begin
      tick(1'b0, a, d);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd; logic er, eer;
    tick(1'b0, 0, 0); tick(1'b0, 0, 0);
    checks++;
    if ({pready0, pslverr0, prdata0, period0, pulse0, size0, enable0} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {period0, pulse0, size0, enable0});
    end
    preset = 0;
    apb0(1, 12'h008, 32'h55, '0, rd, er, erd, eer);
    apb0(1, 12'h00C, 32'h1, '0, rd, er, erd, eer);
    apb0(1, 12'h020, 32'h1234, '0, rd, er, erd, eer);
    tick(1'b0, 0, 0);
    psel3 = 1; penable = 0; pwrite = 1; paddr = 12'h008; pwdata = 32'h77;
    tick(1'b0, 0, 0);
    penable = 1;
    tick(1'b0, 0, 0);
    preset = 1;
    #1;
    checks++;
    if (pready3 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_access_pready got=%b exp=0", pready3);
    end
    tick(1'b0, 0, 0);
    preset = 0; psel3 = 0; penable = 0;
    #1;
    checks++;
    if ({pready0, period0, pulse0, size0, enable0, pready3, size3, enable3} !== '0) begin
      errors++;
      $display("FAIL reset_clears got=%h/%h/%h exp=0", {period0, pulse0}, size0, enable0);
    end
    apb0(0, 12'h100, 0, '0, rd, er, erd, eer);
    checks++;
    if (rd !== 32'h0 || erd !== 32'h0) begin
      errors++; $display("FAIL reset_status got=%h exp=0", rd);
    end
  endtask

  task automatic test_period_disabled();
    logic [31:0] rd, erd; logic er, eer;
    apb0(1, 12'h010, 32'h3E8, '0, rd, er, erd, eer);
    tick(1'b0, 0, 0);
    checks++;
    if (period0[DW +: DW] !== 16'h03E8 || 32'(period0[DW +: DW]) !== m_act_per[1]) begin
      errors++; $display("FAIL ch1_period got=%h exp=%h", period0[DW +: DW], 16'h03E8);
    end
    apb0(0, 12'h010, 0, '0, rd, er, erd, eer);
    checks++;
    if (rd !== 32'h3E8 || er !== 1'b0) begin
      errors++; $display("FAIL ch1_period_read got=%h err=%b exp=000003e8", rd, er);
    end
  endtask

  task automatic test_shadow();
    logic [31:0] rd, erd; logic er, eer;
    apb0(1, 12'h00C, 32'h1, '0, rd, er, erd, eer);
    tick(1'b0, 0, 0);
    apb0(1, 12'h004, 32'h64, '0, rd, er, erd, eer);
    tick(1'b0, 0, 0); tick(1'b0, 0, 0);
    checks++;
    if (pulse0[0 +: DW] !== 16'h0 || 32'(pulse0[0 +: DW]) !== m_act_pul[0]) begin
      errors++; $display("FAIL shadow_hold got=%h exp=0", pulse0[0 +: DW]);
    end
    apb0(0, 12'h100, 0, '0, rd, er, erd, eer);
    checks++;
    if (rd !== 32'h1 || rd !== erd) begin
      errors++; $display("FAIL status_pending got=%h exp=1", rd);
    end
    reload = 4'b0001;
    tick(1'b0, 0, 0);
    reload = '0;
    checks++;
    if (pulse0[0 +: DW] !== 16'h64) begin
      errors++; $display("FAIL reload_pulse got=%h exp=64", pulse0[0 +: DW]);
    end
    apb0(0, 12'h100, 0, '0, rd, er, erd, eer);
    checks++;
    if (rd !== 32'h0 || rd !== erd) begin
      errors++; $display("FAIL status_cleared got=%h exp=0", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int lat;
    apb3(1, 12'h008, 32'h5A, rd, lat);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL ws3_write_latency got=%0d exp=3", lat);
    end
    psel3 = 1; penable = 0; pwrite = 0; paddr = 12'h008;
    tick(1'b0, 0, 0);
    penable = 1;
    lat = -1; rd = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (pready3 === 1'b1) begin lat = k; rd = prdata3; break; end
      checks++;
      if (prdata3 !== 32'h0) begin
        errors++; $display("FAIL ws3_prdata_idle got=%h exp=0", prdata3);
      end
      tick(1'b0, 0, 0);
    end
    checks++;
    if (lat !== 3 || rd !== 32'h5A) begin
      errors++; $display("FAIL ws3_read got=lat%0d/%h exp=lat3/0000005a", lat, rd);
    end
    tick(1'b0, 0, 0);
    checks++;
    if (pready3 !== 1'b0) begin
      errors++; $display("FAIL ws3_pready_width got=%b exp=0", pready3);
    end
    psel3 = 0; penable = 0;
    tick(1'b0, 0, 0);
    psel3 = 1; penable = 0; pwrite = 1; paddr = 12'h008; pwdata = 32'h11;
    tick(1'b0, 0, 0);
    penable = 1;
    tick(1'b0, 0, 0);
    psel3 = 0; penable = 0;
    tick(1'b0, 0, 0); tick(1'b0, 0, 0);
    checks++;
    if (size3[7:0] !== 8'h5A || pready3 !== 1'b0) begin
      errors++; $display("FAIL ws3_abort got=%h exp=5a", size3[7:0]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer;
    logic [11:0] addrs [5] = '{12'h002, 12'h040, 12'h100, 12'h104, 12'h0F8};
    bit wr [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apb0(wr[i], addrs[i], 32'hDEAD_BEEF, '0, rd, er, erd, eer);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || eer !== 1'b1) begin
        errors++; $display("FAIL err_%h got=err%b/%h exp=err1/0", addrs[i], er, rd);
      end
    end
    tick(1'b0, 0, 0);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if ({period0[c*DW +: DW], pulse0[c*DW +: DW], size0[c*8 +: 8], enable0[c]} !==
          {m_act_per[c][DW-1:0], m_act_pul[c][DW-1:0], m_size[c], m_en[c]}) begin
        errors++; $display("FAIL err_no_change ch%0d got=%h", c, size0[c*8 +: 8]);
      end
    end
  endtask

  task automatic test_size_collision();
    logic [31:0] rd, erd; logic er, eer;
    apb0(1, 12'h008, 32'hFFFF_FFAB, '0, rd, er, erd, eer);
    checks++;
    if (size0[7:0] !== 8'hAB) begin
      errors++; $display("FAIL size_narrow got=%h exp=ab", size0[7:0]);
    end
    apb0(0, 12'h008, 0, '0, rd, er, erd, eer);
    checks++;
    if (rd !== 32'hAB) begin
      errors++; $display("FAIL size_read got=%h exp=000000ab", rd);
    end
    apb0(1, 12'h000, 32'h1111, '0, rd, er, erd, eer);
    tick(1'b0, 0, 0);
    apb0(1, 12'h000, 32'h2222, 4'b0001, rd, er, erd, eer);
    checks++;
    if (period0[0 +: DW] !== 16'h1111 || m_act_per[0] !== 32'h1111) begin
      errors++; $display("FAIL collision_active got=%h exp=1111", period0[0 +: DW]);
    end
    apb0(0, 12'h100, 0, '0, rd, er, erd, eer);
    checks++;
    if (rd[0] !== 1'b1 || rd !== erd) begin
      errors++; $display("FAIL collision_status got=%h exp=%h", rd, erd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, d; logic er, eer; logic [11:0] a; bit w;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) a = 12'($urandom_range(0, 12'h1FF));
      else if ($urandom_range(0, 7) == 0) a = 12'h100;
      else a = {4'h0, 4'($urandom_range(0, NCH - 1)), 2'($urandom_range(0, 3)), 2'b00};
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      apb0(w, a, d, NCH'($urandom), rd, er, erd, eer);
      checks++;
      if (rd !== erd || er !== eer) begin
        errors++; $display("FAIL rand_xfer a=%h w=%b got=%h/%b exp=%h/%b", a, w, rd, er, erd, eer);
      end
      reload = NCH'($urandom);
      tick(1'b0, 0, 0);
      reload = '0;
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if ({period0[c*DW +: DW], pulse0[c*DW +: DW], size0[c*8 +: 8], enable0[c]} !==
            {m_act_per[c][DW-1:0], m_act_pul[c][DW-1:0], m_size[c], m_en[c]}) begin
          errors++;
          $display("FAIL rand_out ch%0d got=%h/%h exp=%h/%h", c, period0[c*DW +: DW],
                   pulse0[c*DW +: DW], m_act_per[c], m_act_pul[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_period_disabled();
    test_shadow();
    test_wait_states();
    test_errors();
    test_size_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
